fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, 9, memory/PC address width in bits.
REQ-002 Parameter INSTR_W, 16, instruction width in bits.
REQ-003 Parameter QDEPTH, 2, prefetch queue entries (power of two, >=2).
REQ-004 Parameter RESET_PC, 0, fetch address after reset.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 mem_cmd  output  2  memory command; MNONE=2'b00, MREAD=2'b10; MWRITE=2'b01 is never driven.
REQ-008 mem_addr  output  ADDR_W  fetch address; valid while mem_cmd=MREAD.
REQ-009 mem_rdata  input  INSTR_W  read data; valid when mem_ready=1.
REQ-010 mem_ready  input  1  read completes this cycle (wait states allowed).
REQ-011 ir_valid  output  1  queue head holds a valid instruction.
REQ-012 ir_data  output  INSTR_W  queue head instruction.
REQ-013 ir_pc  output  ADDR_W  address the head instruction was fetched from.
REQ-014 ir_ready  input  1  consumer accepts the head when ir_valid=1.
REQ-015 redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc.
REQ-016 redirect_pc  input  ADDR_W  new fetch address; sampled with redirect.
REQ-017 halt  input  1  stop fetching; level-sampled.
REQ-018 halted  output  1  block is in HALT.

Function
REQ-019 The FSM SHALL have states FETCH, STALL and HALT.
REQ-020 In FETCH the block SHALL drive mem_cmd=MREAD and mem_addr=fetch_pc, holding both stable until mem_ready=1.
REQ-021 On a cycle with MREAD and mem_ready=1, the block SHALL push {fetch_pc, mem_rdata} and set fetch_pc to fetch_pc+1 modulo 2^ADDR_W. All-ones wraps to 0.
REQ-022 With zero wait states (mem_ready tied to 1), throughput SHALL be one instruction per cycle, and ir_valid SHALL rise one cycle after the push.
REQ-023 The block SHALL enter STALL when the queue is full; in STALL it SHALL drive mem_cmd=MNONE and return to FETCH in the cycle after a pop frees an entry.
REQ-024 A pop SHALL occur when ir_valid=1 and ir_ready=1; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-025 The queue SHALL NOT accept a push when full, and a pop when empty SHALL have no effect.
REQ-026 On redirect=1 the block SHALL do all of the following on the next edge: empty the queue, set fetch_pc=redirect_pc, discard any mem_rdata completing in the same cycle, and go to FETCH. Redirect is the only permitted abandonment of a held MREAD.
REQ-027 Redirect SHALL take priority over a same-cycle push, pop or full condition.
REQ-028 halt=1 in FETCH or STALL SHALL move the block to HALT only after any outstanding MREAD completes; the completing data SHALL still be pushed.
REQ-029 In HALT the block SHALL drive mem_cmd=MNONE and halted=1, keep draining queued entries to the consumer, and ignore redirect and halt; only reset exits HALT.
REQ-030 Simultaneous redirect and halt SHALL apply the redirect first, then enter HALT with no new MREAD issued.

Reset
REQ-031 While reset=0, all of the following SHALL hold asynchronously: FSM=FETCH, fetch_pc=RESET_PC, queue empty, mem_cmd=MNONE, ir_valid=0, halted=0.
REQ-032 The first MREAD to RESET_PC SHALL appear in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-read SHALL abandon the read without pushing it.

Structure
REQ-034 The mem_cmd encodings (MNONE/MWRITE/MREAD) and the FSM state typedef SHALL reside in a shared package used by cpu and fetch_unit.
REQ-035 The queue SHALL be a separate sub-module, fetch_queue, parametrised by width (ADDR_W+INSTR_W) and QDEPTH, with push, pop, full, empty and count.

Verification
REQ-036 Reset release, mem_ready=1, ir_ready=1 -> MREAD at addresses 0,1,2,3 on consecutive cycles, and ir_pc 0,1,2 follows one cycle behind.
REQ-037 mem_ready=0 for 3 cycles at addr 5 -> mem_addr held at 5 for 4 cycles, and exactly one push occurs.
REQ-038 ir_ready=0, QDEPTH=2 -> two pushes, then mem_cmd=MNONE (STALL); one pop -> MREAD resumes at the next address the cycle after.
REQ-039 Redirect to 0x1F0 during a waited read of addr 7 with mem_ready=1 the same cycle -> the addr-7 data is not visible, the queue is empty, and the next MREAD is at 0x1F0.
REQ-040 fetch_pc=0x1FF (ADDR_W=9), read completes -> next MREAD at 0x000.
REQ-041 halt during a waited read -> the data is pushed, halted=1 on the next edge, mem_cmd stays MNONE, and queued entries still drain with ir_ready=1.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch path: memory command encodings and the
// fetch FSM state type. Also used by the CPU core.
package fetch_unit_pkg;

  // Memory command bus encodings.
  typedef logic [1:0] mem_cmd_t;
  localparam mem_cmd_t MNONE  = 2'b00;
  localparam mem_cmd_t MWRITE = 2'b01;
  localparam mem_cmd_t MREAD  = 2'b10;

  // Fetch FSM state encodings, kept as plain constants for legacy code.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH = 2'd0;
  localparam fetch_state_t ST_STALL = 2'd1;
  localparam fetch_state_t ST_HALT  = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: a power-of-two circular buffer with an occupancy count.
// Pushes to a full queue and pops from an empty queue are ignored; flush
// empties the queue and wins over a same-cycle push or pop.
module fetch_queue #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the data array has no reset; the count decides which entries are
  // meaningful, so clearing the payload would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential reads to instruction memory,
// buffers {pc, instruction} pairs in a small prefetch queue, and supports
// redirect (flush and restart) and halt (stop fetching, keep draining).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = 9,
  parameter int          INSTR_W  = 16,
  parameter int          QDEPTH   = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [1:0]         mem_cmd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               halted
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;

  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  q_head;

  logic              take_redirect;
  logic              read_done;
  logic              push;
  logic              pop;
  logic              fills;

  // Redirect is ignored once halted; it overrides any push or pop this cycle.
  assign take_redirect = redirect && (state != ST_HALT);
  assign read_done     = (state == ST_FETCH) && mem_ready;
  assign push          = read_done && !take_redirect && !q_full;
  assign pop           = !q_empty && ir_ready && !take_redirect;
  assign fills         = push && !pop && (q_count == CNT_W'(QDEPTH - 1));

  // Next-state selection; redirect first, then halt, then queue pressure.
  // NOTE: state_nxt gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (take_redirect) begin
      state_nxt = halt ? ST_HALT : ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          // A held read must complete before halting.
          if (read_done && halt) state_nxt = ST_HALT;
          else if (fills)        state_nxt = ST_STALL;
        end
        ST_STALL: begin
          if (halt)     state_nxt = ST_HALT;
          else if (pop) state_nxt = ST_FETCH;
        end
        ST_HALT:  state_nxt = ST_HALT;
        default:  state_nxt = ST_FETCH;
      endcase
    end
  end

  // FSM state and fetch address registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_FETCH;
      fetch_pc <= ADDR_W'(RESET_PC);
    end else begin
      state <= state_nxt;
      if (take_redirect) fetch_pc <= redirect_pc;
      else if (push)     fetch_pc <= fetch_pc + 1'b1;
    end
  end

  // The state register already reads FETCH during reset, so the command is
  // gated by reset to keep the bus idle until reset releases.
  assign mem_cmd  = (reset && (state == ST_FETCH)) ? MREAD : MNONE;
  assign mem_addr = fetch_pc;
  assign halted   = (state == ST_HALT);
  assign ir_valid = !q_empty;
  assign ir_pc    = q_head[ENT_W-1:INSTR_W];
  assign ir_data  = q_head[INSTR_W-1:0];

  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (take_redirect),
    .push      (push),
    .push_data ({fetch_pc, mem_rdata}),
    .pop       (pop),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus thread queues the expected
// {pc, instruction} for every read it completes; a monitor pops and compares
// whenever the consumer handshake fires.
module tb_fetch_unit;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b10;

  typedef struct packed {
    logic [8:0]  pc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [8:0]  ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        halt;
  logic        halted;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (9),
    .INSTR_W  (16),
    .QDEPTH   (2),
    .RESET_PC (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_cmd     (mem_cmd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted)
  );

  // Instruction memory image: every address holds a distinct word.
  function automatic logic [15:0] instr_of(input logic [8:0] a);
    return {7'h35, a};
  endfunction

  assign mem_rdata = (mem_cmd == CMD_READ) ? instr_of(mem_addr) : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One read cycle at the expected address; completes when rdy is set.
  task automatic rd(input logic [8:0] addr, input logic rdy);
    mem_ready = rdy;
    check("rd_cmd", mem_cmd, CMD_READ);
    check("rd_addr", mem_addr, addr);
    if (rdy) sb.push_back('{pc: addr, data: instr_of(addr)});
    step();
  endtask

  // Monitor: compare each consumed instruction against the scoreboard.
  always @(negedge clk) begin
    if (reset && ir_valid && ir_ready && !(redirect && !halted)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ir_unexpected: got pc=0x%0h data=0x%0h with none expected", ir_pc, ir_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ir_pc", ir_pc, e.pc);
        check("ir_data", ir_data, e.data);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; mem_ready = 1'b0; ir_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd", mem_cmd, CMD_NONE);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_halted", halted, 0);

    // Zero-wait sequential fetch straight out of reset.
    mem_ready = 1'b1; ir_ready = 1'b1;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("seq_ir_valid", ir_valid, (k > 0));
      if (k > 0) check("seq_ir_pc", ir_pc, k - 1);
      rd(9'(k), 1'b1);
    end
    rd(9'd4, 1'b1);

    // Three wait states on address 5: held four cycles, one push.
    for (int w = 0; w < 3; w++) rd(9'd5, 1'b0);
    rd(9'd5, 1'b1);

    // Drain, then fill the two-entry queue with the consumer stalled.
    rd(9'd6, 1'b0);
    ir_ready = 1'b0;
    check("stall_pre_empty", ir_valid, 0);
    rd(9'd6, 1'b1);
    rd(9'd7, 1'b1);
    for (int s = 0; s < 2; s++) begin
      check("stall_cmd", mem_cmd, CMD_NONE);
      check("stall_head", ir_pc, 6);
      step();
    end
    ir_ready = 1'b1;
    check("stall_pop_cmd", mem_cmd, CMD_NONE);
    step();

    // Resumed at 8; redirect to 7 while entry 7 is still queued.
    mem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 9'h007;
    sb.delete();
    check("resume_cmd", mem_cmd, CMD_READ);
    check("resume_addr", mem_addr, 8);
    step();
    redirect = 1'b0;
    ir_ready = 1'b0;
    check("redir_flush", ir_valid, 0);

    // Waited read of 7, then redirect in the cycle it completes.
    rd(9'd7, 1'b0);
    rd(9'd7, 1'b0);
    mem_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 9'h1F0;
    check("redir_done_addr", mem_addr, 7);
    step();
    redirect = 1'b0;
    ir_ready = 1'b1;
    check("redir_drop_valid", ir_valid, 0);
    rd(9'h1F0, 1'b1);

    // Redirect near the top of the address space and wrap past 0x1FF.
    mem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 9'h1FE;
    sb.delete();
    check("wrap_redir_addr", mem_addr, 9'h1F1);
    step();
    redirect = 1'b0;
    rd(9'h1FE, 1'b1);
    rd(9'h1FF, 1'b1);
    rd(9'h000, 1'b1);

    // Halt during a waited read of address 1.
    ir_ready = 1'b0;
    halt = 1'b1;
    check("halt_pre", halted, 0);
    rd(9'd1, 1'b0);
    rd(9'd1, 1'b0);
    rd(9'd1, 1'b1);
    check("halt_halted", halted, 1);
    check("halt_cmd", mem_cmd, CMD_NONE);
    redirect = 1'b1; redirect_pc = 9'h055;
    step();
    redirect = 1'b0;
    check("halt_cmd2", mem_cmd, CMD_NONE);
    check("halt_keep_valid", ir_valid, 1);
    check("halt_keep_head", ir_pc, 0);
    ir_ready = 1'b1;
    step();
    check("halt_drain_cmd", mem_cmd, CMD_NONE);
    step();
    check("halt_drained", ir_valid, 0);
    check("halt_still", halted, 1);
    check("sb_drained", sb.size(), 0);

    // Asynchronous reset exits HALT immediately.
    reset = 1'b0;
    sb.delete();
    #1;
    check("rst2_cmd", mem_cmd, CMD_NONE);
    check("rst2_halted", halted, 0);
    check("rst2_ir_valid", ir_valid, 0);
    halt = 1'b0; mem_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    rd(9'd0, 1'b0);

    // Reset mid-read with the read completing while reset is held.
    mem_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_cmd", mem_cmd, CMD_NONE);
    step();
    reset = 1'b1;
    #1;
    check("rst_mid_nopush", ir_valid, 0);
    rd(9'd0, 1'b1);
    rd(9'd1, 1'b1);

    // Simultaneous redirect and halt: flush, then halt with no new read.
    redirect = 1'b1; halt = 1'b1; redirect_pc = 9'h0A0;
    sb.delete();
    check("rh_addr", mem_addr, 2);
    step();
    redirect = 1'b0;
    check("rh_halted", halted, 1);
    check("rh_cmd", mem_cmd, CMD_NONE);
    check("rh_flushed", ir_valid, 0);
    step();
    check("rh_cmd2", mem_cmd, CMD_NONE);
    check("sb_final", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
